uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/uart_tx_bit_timer.sv | 49 ++++
 rtl/uart_tx.sv | 150 +++++++++++++++
 tb/tb_uart_tx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, parity
// constants and the prescale decoding used by both the FSM and the bit timer.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_t;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    localparam int PRESCALE_W = 5;
    localparam int EDGE_W     = PRESCALE_W + 1;

    // A prescale of zero selects the longest bit period, 32 clocks.
    function automatic logic [EDGE_W-1:0] bitCycles(input logic [PRESCALE_W-1:0] prescale);
        logic [EDGE_W-1:0] cycles;
        if (prescale == '0) begin
            cycles = EDGE_W'(32);
        end else begin
            cycles = {1'b0, prescale};
        end
        return cycles;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the UART transmitter: an edge counter that divides each bit
// into i_bitCycles clocks and a data-bit counter active only in the DATA state.
module tx_bit_timer
    import uart_tx_pkg::*;
#(
    parameter int width = 8
)
(
    input  logic              CLK,
    input  logic              Reset,
    input  logic              i_run,
    input  logic              i_inData,
    input  logic [EDGE_W-1:0] i_bitCycles,
    output logic              o_bitDone,
    output logic              o_lastBit
);

    localparam int BIT_W = (width > 1) ? $clog2(width) : 1;

    logic [EDGE_W-1:0] r_edgeCnt;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [EDGE_W-1:0] w_lastEdge;

    assign w_lastEdge = i_bitCycles - EDGE_W'(1);
    assign o_bitDone  = i_run && (r_edgeCnt == w_lastEdge);
    assign o_lastBit  = i_inData && (r_bitCnt == BIT_W'(width - 1));

    // Both counters sit at zero whenever their qualifying state is not active.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_edgeCnt <= '0;
        end else if (!i_run || o_bitDone) begin
            r_edgeCnt <= '0;
        end else begin
            r_edgeCnt <= r_edgeCnt + EDGE_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_bitCnt <= '0;
        end else if (!i_inData) begin
            r_bitCnt <= '0;
        end else if (o_bitDone) begin
            r_bitCnt <= o_lastBit ? '0 : r_bitCnt + BIT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit,
// with all frame parameters captured when a request is accepted.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int width = 8
)
(
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [width-1:0]      P_Data,
    input  logic                  Data_valid,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  S_Data,
    output logic                  Busy
);

    txState_t          r_state;
    txState_t          w_nextState;
    logic [width-1:0]  r_data;
    logic [width-1:0]  r_shift;
    logic [width-1:0]  w_shiftNext;
    logic              r_parEn;
    logic              r_parType;
    logic [EDGE_W-1:0] r_bitCycles;
    logic              r_sData;
    logic              r_busy;
    logic              w_accept;
    logic              w_bitDone;
    logic              w_lastBit;
    logic              w_parityBit;
    logic              w_sDataNext;

    assign w_accept    = (r_state == IDLE) && !r_busy && Data_valid;
    assign w_parityBit = (^r_data) ^ (r_parType == ODD);
    assign S_Data      = r_sData;
    assign Busy        = r_busy;

    tx_bit_timer #(
        .width(width)
    ) u_bitTimer (
        .CLK        (CLK),
        .Reset      (Reset),
        .i_run      (r_state != IDLE),
        .i_inData   (r_state == DATA),
        .i_bitCycles(r_bitCycles),
        .o_bitDone  (w_bitDone),
        .o_lastBit  (w_lastBit)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = START;
                end
            end
            START: begin
                if (w_bitDone) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_bitDone && w_lastBit) begin
                    w_nextState = r_parEn ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bitDone) begin
                    w_nextState = STOP;
                end
            end
            STOP: begin
                if (w_bitDone) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The untouched copy in r_data feeds the parity generator; r_shift is consumed.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_data      <= '0;
            r_parEn     <= 1'b0;
            r_parType   <= EVEN;
            r_bitCycles <= '0;
        end else if (w_accept) begin
            r_data      <= P_Data;
            r_parEn     <= Parity_EN;
            r_parType   <= Parity_type;
            r_bitCycles <= bitCycles(Prescale);
        end
    end

    always_comb begin
        w_shiftNext = r_shift;
        if (w_accept) begin
            w_shiftNext = P_Data;
        end else if ((r_state == DATA) && w_bitDone) begin
            w_shiftNext = r_shift >> 1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_shift <= '0;
        end else begin
            r_shift <= w_shiftNext;
        end
    end

    // Output mux looks ahead one state so the serial line itself can be registered.
    always_comb begin
        w_sDataNext = 1'b1;
        case (w_nextState)
            IDLE:    w_sDataNext = 1'b1;
            START:   w_sDataNext = 1'b0;
            DATA:    w_sDataNext = w_shiftNext[0];
            PARITY:  w_sDataNext = w_parityBit;
            STOP:    w_sDataNext = 1'b1;
            default: w_sDataNext = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_sData <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_sData <= w_sDataNext;
            r_busy  <= (w_nextState != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a table of hand-computed frames plus sequences
// for back-to-back requests, ignored requests and reset in mid-frame.
module tb_uart_tx;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [7:0] P_Data;
    logic       Data_valid;
    logic       Parity_EN;
    logic       Parity_type;
    logic [4:0] Prescale;
    logic       S_Data;
    logic       Busy;

    integer vectorsApplied = 0;
    integer miscompares    = 0;

    // expFrame bit i is the i-th serial bit, start bit first.
    typedef struct {
        logic [7:0]  data;
        logic        parEn;
        logic        parType;
        logic [4:0]  presc;
        logic [11:0] expFrame;
        integer      expBusy;
    } vec_t;

    vec_t vecs[5];

    uart_tx #(.width(8)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .P_Data     (P_Data),
        .Data_valid (Data_valid),
        .Parity_EN  (Parity_EN),
        .Parity_type(Parity_type),
        .Prescale   (Prescale),
        .S_Data     (S_Data),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic checkEq(input string name, input integer actual, input integer expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Presents a request so it is accepted on the next rising edge, then returns
    // 1 time unit after that edge with the inputs scrambled unless holding.
    task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt,
                                 input logic [4:0] ps, input logic hold);
        @(negedge CLK);
        P_Data      = d;
        Parity_EN   = pe;
        Parity_type = pt;
        Prescale    = ps;
        Data_valid  = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) begin
            Data_valid  = 1'b0;
            P_Data      = ~d;
            Parity_EN   = ~pe;
            Parity_type = ~pt;
            Prescale    = ps + 5'd3;
        end
    endtask

    // Walks the frame cycle by cycle while Busy is high, bounded at 400 cycles.
    task automatic checkOutput(input string name, input logic [11:0] expFrame,
                               input integer bitCyc, input integer expBusy,
                               input integer pulseAt);
        integer cyc;
        integer firstBad;
        integer idx;
        cyc      = 0;
        firstBad = -1;
        while (Busy === 1'b1 && cyc < 400) begin
            idx = cyc / bitCyc;
            if (firstBad < 0) begin
                if (idx > 11) begin
                    firstBad = cyc;
                end else if (S_Data !== expFrame[idx]) begin
                    firstBad = cyc;
                end
            end
            if (pulseAt >= 0) begin
                if (cyc == pulseAt) begin
                    Data_valid = 1'b1;
                    P_Data     = 8'hFF;
                end else begin
                    Data_valid = 1'b0;
                end
            end
            @(posedge CLK);
            #1;
            cyc++;
        end
        if (pulseAt >= 0) begin
            Data_valid = 1'b0;
        end
        checkEq({name, " firstBadCycle"}, firstBad, -1);
        checkEq({name, " busyCycles"}, cyc, expBusy);
        checkEq({name, " idle S_Data"}, S_Data, 1);
    endtask

    task automatic checkNoFrame(input string name);
        integer busySeen;
        busySeen = 0;
        repeat (20) begin
            @(posedge CLK);
            #1;
            if (Busy !== 1'b0) begin
                busySeen++;
            end
        end
        checkEq({name, " stray busy cycles"}, busySeen, 0);
    endtask

    initial begin
        integer bitCyc;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 5'd8, 12'h34A, 80};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 5'd5, 12'h406, 55};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 5'd5, 12'h606, 55};
        vecs[3] = '{8'h81, 1'b0, 1'b0, 5'd0, 12'h302, 320};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 5'd2, 12'h7FE, 22};

        Reset       = 1'b1;
        P_Data      = 8'h00;
        Data_valid  = 1'b0;
        Parity_EN   = 1'b0;
        Parity_type = 1'b0;
        Prescale    = 5'd1;
        #12;
        checkEq("reset S_Data", S_Data, 1);
        checkEq("reset Busy", Busy, 0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        checkEq("post-reset idle S_Data", S_Data, 1);

        for (int i = 0; i < 5; i++) begin
            bitCyc = (vecs[i].presc == 5'd0) ? 32 : int'(vecs[i].presc);
            applyStimulus(vecs[i].data, vecs[i].parEn, vecs[i].parType, vecs[i].presc, 1'b0);
            checkOutput($sformatf("vec%0d", i), vecs[i].expFrame, bitCyc, vecs[i].expBusy, -1);
        end

        // Data_valid held high across two frames: one idle-high cycle between them.
        applyStimulus(8'h55, 1'b0, 1'b0, 5'd16, 1'b1);
        P_Data = 8'hAA;
        checkOutput("b2b first", 12'h2AA, 16, 160, -1);
        @(posedge CLK);
        #1;
        Data_valid = 1'b0;
        checkOutput("b2b second", 12'h354, 16, 160, -1);

        // Requests during a frame, including its final stop-bit cycle, are dropped.
        applyStimulus(8'h00, 1'b0, 1'b0, 5'd4, 1'b0);
        checkOutput("drop mid", 12'h200, 4, 40, 13);
        checkNoFrame("drop mid");
        applyStimulus(8'h00, 1'b0, 1'b0, 5'd4, 1'b0);
        checkOutput("drop stop", 12'h200, 4, 40, 39);
        checkNoFrame("drop stop");

        // Reset while data bit 3 (cycles 16..19) of an all-zero frame is on the line.
        applyStimulus(8'h00, 1'b0, 1'b0, 5'd4, 1'b0);
        repeat (17) begin
            @(posedge CLK);
            #1;
        end
        checkEq("pre-reset data bit3", S_Data, 0);
        checkEq("pre-reset Busy", Busy, 1);
        #2;
        Reset = 1'b1;
        #1;
        checkEq("midframe reset S_Data", S_Data, 1);
        checkEq("midframe reset Busy", Busy, 0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        applyStimulus(8'h5A, 1'b0, 1'b0, 5'd4, 1'b0);
        checkOutput("after reset 5A", 12'h2B4, 4, 40, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
